muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative multiply/divide execute unit implementing the RV32M/RV64M `funct3` operation set for the pipelined core. It sits beside the ALU in the Execute stage. It accepts one operation per `start` pulse and holds `busy` so the hazard unit stalls Fetch/Decode/Execute. It returns a single-cycle `done` with the result and destination register for the EX/MEM register.

## Interface
- `XLEN`, default 32: operand/result width. Must be even and ≥8.
- `REG_W`, default 5: destination-register index width.
- `clk` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-low reset.
- `start` input 1: request; operands sampled when accepted.
- `flush` input 1: abort the in-flight operation (driven from `flushE`).
- `op` input 3: `funct3`. 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `a`, `b` input XLEN: rs1/rs2 values, already forwarded.
- `rd_in` input REG_W: destination register.
- `busy` output 1: operation in progress (state BUSY).
- `done` output 1: result valid this cycle only.
- `result` output XLEN: operation result, held until the next `done`.
- `rd_out` output REG_W: destination register accompanying `done`.

## Operation
- States: IDLE, BUSY, DONE.
- `start` is accepted in IDLE or DONE when `flush`=0. `start` in BUSY is ignored.
- On acceptance:
  - latch `op` and `rd_in`;
  - convert signed operands to magnitude: MULH signs `a` and `b`, MULHSU signs `a` only, DIV/REM sign both;
  - record the result sign;
  - load counter = XLEN.
- Transition IDLE/DONE→BUSY, except for these shortcuts, which go directly to DONE:
  - divide by zero (`b`=0, ops 4-7): quotient = all ones, remainder = `a` unmodified;
  - signed overflow (`a`=100…0 with `b`=all ones, ops 4/6): DIV = `a`, REM = 0.
- BUSY, multiply: radix-2 shift-add over a 2·XLEN accumulator, one bit per cycle.
- BUSY, divide: restoring, one quotient bit per cycle.
- Counter decrements each cycle in BUSY. When it reaches 1, go to DONE.
- At DONE entry:
  - apply sign fix-up: two's-complement negate the product or quotient if the result sign is set; the remainder takes the dividend's sign;
  - select the low XLEN bits (MUL) or high XLEN bits (MULH*), quotient or remainder;
  - register into `result`.
- DONE→IDLE next cycle, unless a new `start` is accepted.
- `flush`=1 in any state → IDLE next edge. It takes priority over `start`. No `done` is emitted. `result` is unchanged.
- Reset mid-operation: immediate abort, all state cleared.
- Reset values: state IDLE, `busy`=0, `done`=0, `result`=0, `rd_out`=0, counter 0.

## Timing
- `start` accepted at edge T.
- Iterative operation:
  - `busy`=1 for cycles T+1 … T+XLEN;
  - `done`=1 in cycle T+XLEN+1 (33-cycle latency at XLEN=32).
- Shortcut cases: `done`=1 in cycle T+1 and `busy` never asserts.
- `busy` and `done` are registered (no combinational path from inputs). The hazard unit combines `start` with `busy` to stall in cycle T.
- Back-to-back: `start` in the DONE cycle begins BUSY at the next edge. Throughput is one operation per XLEN+1 cycles.

## Configuration
- `MULDIV_FAST_MUL_EN` defined:
  - ops 0-3 use a single combinational 2·XLEN signed multiplier;
  - IDLE→DONE directly, with `done` at T+1;
  - division is unchanged.
- `MULDIV_FAST_MUL_EN` undefined: multiply is iterative, as described under Operation, with latency XLEN+1.
- All other behaviour is identical in both configurations.

## Test plan
- XLEN=32, MUL `a`=7, `b`=−3, `rd_in`=5 → `done` at T+33 (T+1 with fast mul), `result`=0xFFFFFFEB, `rd_out`=5.
- MULHU `a`=`b`=0xFFFFFFFF → `result`=0xFFFFFFFE. MULH same operands → 0x00000000. MULHSU `a`=0xFFFFFFFF, `b`=2 → 0xFFFFFFFF.
- DIV −7/2 → 0xFFFFFFFD. REM −7/2 → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2. Each has `done` at T+33.
- DIVU 5/0 → 0xFFFFFFFF and REMU 5/0 → 5, with `done` at T+1 and `busy` never high. DIV 0x80000000/−1 → 0x80000000 and REM → 0, also at T+1.
- `flush` at T+10 of a DIV → IDLE at T+11, no `done`, `result` keeps its old value. A `start` in BUSY is ignored. `start` during the DONE cycle → the second `done` arrives exactly 33 cycles later.
- `reset` low at T+5 of a MUL → `busy`, `done`, `result` = 0 asynchronously. After release, a fresh MUL 3×4 → 12.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit (shift-add multiply, restoring divide); MULDIV_FAST_MUL_EN selects a single-cycle multiplier.
// Latency: XLEN+1 cycles iterative, 1 cycle for divide-by-zero/overflow shortcuts (and for multiplies with MULDIV_FAST_MUL_EN).
// Backpressure: start is ignored while busy; the hazard unit stalls on start|busy, flush aborts without a done.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             flush,
  input  logic [2:0]       op,
  input  logic [XLEN-1:0]  a,
  input  logic [XLEN-1:0]  b,
  input  logic [REG_W-1:0] rd_in,
  output logic             busy,
  output logic             done,
  output logic [XLEN-1:0]  result,
  output logic [REG_W-1:0] rd_out
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t            state;
  logic [2:0]        op_q;
  logic [REG_W-1:0]  rd_q;
  logic              res_neg;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opnd_b;

  logic              a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              div0, ovf, accept;
  logic [XLEN-1:0]   short_res;
  logic [XLEN:0]     mul_sum, div_r, div_diff;
  logic [2*XLEN-1:0] mul_next, div_next, step, prod_fix;
  logic [XLEN-1:0]   quot_rem, qr_fix, fin_res;

  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    case (op)
      3'd1, 3'd4, 3'd6: begin a_sgn = 1'b1; b_sgn = 1'b1; end
      3'd2:             a_sgn = 1'b1;
      default:          ;
    endcase
  end

  assign a_neg  = a_sgn & a[XLEN-1];
  assign b_neg  = b_sgn & b[XLEN-1];
  assign a_mag  = a_neg ? -a : a;
  assign b_mag  = b_neg ? -b : b;
  assign div0   = op[2] && (b == '0);
  assign ovf    = op[2] && !op[0] && (a == MIN_NEG) && (b == '1);
  assign accept = start && !flush && (state != S_BUSY);

  // Remainder ops have op[1] set; divide-by-zero and overflow bypass the iteration.
  always_comb begin
    short_res = '0;
    if (div0)     short_res = op[1] ? a : '1;
    else if (ovf) short_res = op[1] ? '0 : a;
  end

  // acc holds {partial product, multiplier} for multiply and {remainder, dividend} for divide.
  assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? opnd_b : {XLEN{1'b0}})};
  assign mul_next = {mul_sum, acc[XLEN-1:1]};
  assign div_r    = acc[2*XLEN-1:XLEN-1];
  assign div_diff = div_r - {1'b0, opnd_b};
  assign div_next = div_diff[XLEN] ? {div_r[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                   : {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
  assign step     = op_q[2] ? div_next : mul_next;

  assign prod_fix = res_neg ? -step : step;
  assign quot_rem = op_q[1] ? step[2*XLEN-1:XLEN] : step[XLEN-1:0];
  assign qr_fix   = res_neg ? -quot_rem : quot_rem;

  always_comb begin
    case (op_q)
      3'd0:             fin_res = prod_fix[XLEN-1:0];
      3'd1, 3'd2, 3'd3: fin_res = prod_fix[2*XLEN-1:XLEN];
      default:          fin_res = qr_fix;
    endcase
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_a, fast_b, fast_prod;
  logic [XLEN-1:0]   fast_res;
  logic              fast_sel;
  assign fast_a    = {{XLEN{a_neg}}, a};
  assign fast_b    = {{XLEN{b_neg}}, b};
  assign fast_prod = fast_a * fast_b;
  assign fast_res  = (op == 3'd0) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
  assign fast_sel  = !op[2];
`else
  logic [XLEN-1:0]   fast_res;
  logic              fast_sel;
  assign fast_res  = '0;
  assign fast_sel  = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      op_q    <= '0;
      rd_q    <= '0;
      res_neg <= 1'b0;
      cnt     <= '0;
      acc     <= '0;
      opnd_b  <= '0;
      result  <= '0;
      rd_out  <= '0;
    end else if (flush) begin
      state <= S_IDLE;
    end else if (accept) begin
      op_q    <= op;
      rd_q    <= rd_in;
      res_neg <= op[2] && op[1] ? a_neg : (a_neg ^ b_neg);
      cnt     <= CW'(XLEN);
      acc     <= {{XLEN{1'b0}}, a_mag};
      opnd_b  <= b_mag;
      if (div0 || ovf) begin
        state  <= S_DONE;
        result <= short_res;
        rd_out <= rd_in;
      end else if (fast_sel) begin
        state  <= S_DONE;
        result <= fast_res;
        rd_out <= rd_in;
      end else begin
        state <= S_BUSY;
      end
    end else begin
      case (state)
        S_BUSY: begin
          acc <= step;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state  <= S_DONE;
            result <= fin_res;
            rd_out <= rd_q;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state == S_BUSY);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table plus flush, ignored-start, back-to-back and reset sequences.
module tb_muldiv_unit;

`ifdef MULDIV_FAST_MUL_EN
  localparam int ML = 1;
`else
  localparam int ML = 33;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start, flush;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic [4:0]  rd_in;
  logic        busy, done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32), .REG_W(5)) dut (
    .clk(clk), .reset(reset), .start(start), .flush(flush), .op(op),
    .a(a), .b(b), .rd_in(rd_in), .busy(busy), .done(done),
    .result(result), .rd_out(rd_out)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [4:0] r);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y; rd_in = r;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Cycle k=1 is the cycle right after the accepting edge.
  task automatic wait_done(output int lat, output int busy_cnt);
    lat = -1;
    busy_cnt = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    int lat, bc, first, second;
    logic [31:0] r1, r2;
    logic [4:0]  d1, d2;
    logic        saw_done;

    vecs[0]  = '{3'd0, 32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, ML};
    vecs[1]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  32'hFFFFFFFE, ML};
    vecs[2]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'h00000000, ML};
    vecs[3]  = '{3'd2, 32'hFFFFFFFF, 32'd2,        5'd8,  32'hFFFFFFFF, ML};
    vecs[4]  = '{3'd0, 32'h12345678, 32'h10,       5'd9,  32'h23456780, ML};
    vecs[5]  = '{3'd4, 32'hFFFFFFF9, 32'd2,        5'd10, 32'hFFFFFFFD, 33};
    vecs[6]  = '{3'd6, 32'hFFFFFFF9, 32'd2,        5'd11, 32'hFFFFFFFF, 33};
    vecs[7]  = '{3'd5, 32'd100,      32'd7,        5'd12, 32'd14,       33};
    vecs[8]  = '{3'd7, 32'd100,      32'd7,        5'd13, 32'd2,        33};
    vecs[9]  = '{3'd4, 32'd7,        32'hFFFFFFFE, 5'd14, 32'hFFFFFFFD, 33};
    vecs[10] = '{3'd6, 32'd7,        32'hFFFFFFFE, 5'd15, 32'd1,        33};
    vecs[11] = '{3'd5, 32'd5,        32'd0,        5'd16, 32'hFFFFFFFF, 1};
    vecs[12] = '{3'd7, 32'd5,        32'd0,        5'd17, 32'd5,        1};
    vecs[13] = '{3'd6, 32'hFFFFFFF9, 32'd0,        5'd18, 32'hFFFFFFF9, 1};
    vecs[14] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd19, 32'h80000000, 1};
    vecs[15] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd20, 32'd0,        1};

    reset = 1'b0; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0; rd_in = '0;
    #3;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_result", result, 0);
    check("reset_rd_out", rd_out, 0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 16; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd);
      wait_done(lat, bc);
      check($sformatf("v%0d_lat", i), lat, vecs[i].lat);
      check($sformatf("v%0d_busy_cycles", i), bc, vecs[i].lat - 1);
      check($sformatf("v%0d_result", i), result, vecs[i].exp);
      check($sformatf("v%0d_rd_out", i), rd_out, vecs[i].rd);
      @(negedge clk);
      check($sformatf("v%0d_done_1cyc", i), done, 0);
    end

    // Flush in cycle T+10 of a DIV: no done, result keeps REM 0x80000000/-1 = 0.
    issue(3'd5, 32'd100, 32'd7, 5'd21);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush_idle_busy", busy, 0);
    saw_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check("flush_no_done", saw_done, 0);
    check("flush_result_kept", result, 32'd0);

    // A start pulse mid-BUSY must not disturb the running DIVU.
    issue(3'd5, 32'd100, 32'd7, 5'd3);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
      if (k == 5) begin
        start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd4; rd_in = 5'd1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check("ignore_lat", lat, 33);
    check("ignore_result", result, 32'd14);
    check("ignore_rd_out", rd_out, 5'd3);

    // Back-to-back: new start in the DONE cycle.
    issue(3'd5, 32'd100, 32'd7, 5'd10);
    first = -1; second = -1; r1 = '0; r2 = '0; d1 = '0; d2 = '0;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        if (first < 0) begin
          first = k; r1 = result; d1 = rd_out;
          start = 1'b1; op = 3'd7; a = 32'd100; b = 32'd7; rd_in = 5'd11;
        end else begin
          second = k; r2 = result; d2 = rd_out;
          break;
        end
      end
    end
    start = 1'b0;
    check("b2b_first_lat", first, 33);
    check("b2b_gap", second - first, 33);
    check("b2b_first_result", r1, 32'd14);
    check("b2b_first_rd", d1, 5'd10);
    check("b2b_second_result", r2, 32'd2);
    check("b2b_second_rd", d2, 5'd11);

    // Asynchronous reset in cycle T+5 of a MUL.
    issue(3'd0, 32'd7, 32'hFFFFFFFD, 5'd5);
    repeat (5) @(negedge clk);
    #1 reset = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_result", result, 0);
    check("arst_rd_out", rd_out, 0);
    @(negedge clk);
    reset = 1'b1;
    issue(3'd0, 32'd3, 32'd4, 5'd2);
    wait_done(lat, bc);
    check("post_rst_lat", lat, ML);
    check("post_rst_result", result, 32'd12);
    check("post_rst_rd_out", rd_out, 5'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
